// File: rtl/minterm_pkg.sv
// rtl/minterm_pkg.sv - shared types and constants for the minterm scan sequencer
package minterm_pkg;

  localparam int N_IN    = 4;
  localparam int N_CODES = 2 ** N_IN;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_t;

endpackage

// File: rtl/minterm_scan_ctrl.sv
// rtl/minterm_scan_ctrl.sv - sweeps all input codes into a 4-input function unit
// and checks its SOP/POS outputs against an expected minterm mask
module minterm_scan_ctrl
  import minterm_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   care_mask,
  input  logic [2**N_IN-1:0]   expect_mask,
  input  logic                 out_sop,
  input  logic                 out_pos,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 d,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      fail_idx,
  output logic [2**N_IN-1:0]   tt_sop,
  output logic [2**N_IN-1:0]   tt_pos
);

  localparam int NC = 2 ** N_IN;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(NC - 1);

  scan_state_t       state;
  logic [N_IN-1:0]   idx;
  logic [CW-1:0]     cnt;
  logic [NC-1:0]     care_q;
  logic [NC-1:0]     exp_q;
  logic              mism;

  // idx is parked at 0 outside a sweep, so the unit sees code 0 while idle
  assign {a, b, c, d} = idx[3:0];
  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign mism = care_q[idx] & ((out_sop != exp_q[idx]) | (out_pos != exp_q[idx]));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      care_q    <= '0;
      exp_q     <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_idx  <= '0;
      tt_sop    <= '0;
      tt_pos    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            care_q    <= care_mask;
            exp_q     <= expect_mask;
            tt_sop    <= '0;
            tt_pos    <= '0;
            err_count <= '0;
            fail_idx  <= '0;
            idx       <= '0;
            cnt       <= '0;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          if (abort) begin
            idx   <= '0;
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SAMPLE: begin
          // abort wins over the capture so a partial sweep never records this code
          if (abort) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            tt_sop[idx] <= out_sop;
            tt_pos[idx] <= out_pos;
            if (mism) begin
              err_count <= err_count + 1'b1;
              if (err_count == '0) fail_idx <= idx;
            end
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              cnt   <= '0;
              state <= DRIVE;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (err_count == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_scan_ctrl.sv
// tb/tb_minterm_scan_ctrl.sv - directed self-checking bench for minterm_scan_ctrl
module tb_minterm_scan_ctrl;

  localparam logic [15:0] EXP  = 16'h8084;
  localparam logic [15:0] CARE = 16'hE6F7;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] care_mask = '0;
  logic [15:0] expect_mask = '0;
  logic        out_sop, out_pos;
  logic        a, b, c, d, busy, done, pass;
  logic [4:0]  err_count;
  logic [3:0]  fail_idx;
  logic [15:0] tt_sop, tt_pos;

  logic [15:0] sop_tab = '0;
  logic [15:0] pos_tab = '0;
  logic        m_pass = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // behavioural function unit: outputs are a lookup of the applied code
  assign out_sop = sop_tab[{a, b, c, d}];
  assign out_pos = pos_tab[{a, b, c, d}];

  minterm_scan_ctrl #(.N_IN(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .areset(areset), .start(start), .abort(abort),
    .care_mask(care_mask), .expect_mask(expect_mask),
    .out_sop(out_sop), .out_pos(out_pos),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_idx(fail_idx), .tt_sop(tt_sop), .tt_pos(tt_pos)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_abcd"}, {28'd0, a, b, c, d}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_err"}, {27'd0, err_count}, 32'd0);
    chk({tag, "_fail_idx"}, {28'd0, fail_idx}, 32'd0);
    chk({tag, "_tt_sop"}, {16'd0, tt_sop}, 32'd0);
    chk({tag, "_tt_pos"}, {16'd0, tt_pos}, 32'd0);
  endtask

  // One sweep with per-cycle checks; each code occupies two cycles (settle + sample).
  // restart_k/abort_k/reset_k give the cycle index (after start edge) of that event, -1 for none.
  task automatic run_sweep(input string tag, input logic [15:0] sop_t, input logic [15:0] pos_t,
                           input int restart_k, input int abort_k, input int reset_k);
    int          m_err;
    int          m_fail;
    logic [15:0] m_tts, m_ttp;
    logic        aborted, e_busy, e_done;
    int          e_code;
    sop_tab = sop_t;
    pos_tab = pos_t;
    care_mask = CARE;
    expect_mask = EXP;
    m_err = 0;
    m_fail = 0;
    m_tts = '0;
    m_ttp = '0;
    for (int i = 0; i < 16; i++) begin
      if (abort_k < 0 || 2 * i + 2 <= abort_k) begin
        m_tts[i] = sop_t[i];
        m_ttp[i] = pos_t[i];
        if (CARE[i] && (sop_t[i] != EXP[i] || pos_t[i] != EXP[i])) begin
          if (m_err == 0) m_fail = i;
          m_err++;
        end
      end
    end
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == reset_k) begin
        areset = 1'b1;
        #1;
        chk_all_zero({tag, "_midreset"});
        @(negedge clk);
        areset = 1'b0;
        m_pass = 1'b0;
        return;
      end
      aborted = (abort_k >= 0) && (k > abort_k);
      e_busy  = !aborted && (k < 32);
      e_code  = e_busy ? k / 2 : 0;
      e_done  = !aborted && (k == 33);
      chk($sformatf("%s_busy_k%0d", tag, k), {31'd0, busy}, {31'd0, e_busy});
      chk($sformatf("%s_code_k%0d", tag, k), {28'd0, a, b, c, d}, 32'(e_code));
      chk($sformatf("%s_done_k%0d", tag, k), {31'd0, done}, {31'd0, e_done});
      if (k == restart_k) begin
        start = 1'b1;
        care_mask = 16'hFFFF;
        expect_mask = 16'h0000;
      end
      if (k == restart_k + 1) start = 1'b0;
      if (k == abort_k) abort = 1'b1;
      if (k == abort_k + 1) abort = 1'b0;
    end
    if (abort_k < 0) m_pass = (m_err == 0);
    chk({tag, "_err"}, {27'd0, err_count}, 32'(m_err));
    chk({tag, "_fail_idx"}, {28'd0, fail_idx}, 32'(m_fail));
    chk({tag, "_tt_sop"}, {16'd0, tt_sop}, {16'd0, m_tts});
    chk({tag, "_tt_pos"}, {16'd0, tt_pos}, {16'd0, m_ttp});
    chk({tag, "_pass"}, {31'd0, pass}, {31'd0, m_pass});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    areset = 1'b0;
    @(negedge clk);

    run_sweep("t1", EXP, EXP, -1, -1, -1);
    chk("t1_lit_pass", {31'd0, pass}, 32'd1);
    chk("t1_lit_tt_sop", {16'd0, tt_sop}, 32'h8084);
    chk("t1_lit_tt_pos", {16'd0, tt_pos}, 32'h8084);

    run_sweep("t2", EXP, 16'h8094, -1, -1, -1);
    chk("t2_lit_err", {27'd0, err_count}, 32'd1);
    chk("t2_lit_fail_idx", {28'd0, fail_idx}, 32'd4);
    chk("t2_lit_pass", {31'd0, pass}, 32'd0);
    chk("t2_lit_tt_pos", {16'd0, tt_pos}, 32'h8094);

    run_sweep("t3", 16'h808C, EXP, -1, -1, -1);
    chk("t3_lit_pass", {31'd0, pass}, 32'd1);
    chk("t3_lit_err", {27'd0, err_count}, 32'd0);
    chk("t3_lit_tt_sop", {16'd0, tt_sop}, 32'h808C);

    run_sweep("t4", 16'h8280, EXP, -1, -1, -1);
    chk("t4_lit_err", {27'd0, err_count}, 32'd2);
    chk("t4_lit_fail_idx", {28'd0, fail_idx}, 32'd2);
    chk("t4_lit_pass", {31'd0, pass}, 32'd0);

    run_sweep("t5a", EXP, 16'h8094, 12, -1, -1);
    chk("t5a_lit_err", {27'd0, err_count}, 32'd1);
    run_sweep("t5b", EXP, 16'h8094, -1, 10, -1);
    chk("t5b_lit_err", {27'd0, err_count}, 32'd1);
    chk("t5b_lit_tt_pos", {16'd0, tt_pos}, 32'h0014);
    chk("t5b_lit_tt_sop", {16'd0, tt_sop}, 32'h0004);

    run_sweep("t6a", EXP, EXP, -1, -1, 20);
    run_sweep("t6b", EXP, EXP, -1, -1, -1);
    chk("t6_lit_pass", {31'd0, pass}, 32'd1);
    chk("t6_lit_tt_sop", {16'd0, tt_sop}, 32'h8084);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
